aes_job_arbiter: RTL and testbench
==================================

# aes_job_arbiter

Shares one `aes_encrypt` core and one `aes_decrypt` core among `NREQ` requesters. Each requester submits a 128-bit block, a cipher key and a mode (encrypt/decrypt). The block grants requesters in round-robin order and sequences the selected core through load and valid. It returns the result on a single response channel tagged with the requester ID, and returns an error response if the core does not complete within a watchdog limit. It sits between the system-side request sources and the two AES cores.

## Interface
- `Nk`, 4: cipher key length in 32-bit words (4/6/8); passed unchanged to the cores.
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: response ID width.
- `TIMEOUT`, 64: maximum WAIT cycles before an error response, ≥2.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  NREQ: per-requester request valid.
- `req_ready`  out  NREQ: per-requester accept; one-hot or zero.
- `req_mode`  in  NREQ: 0 = encrypt, 1 = decrypt.
- `req_data`  in  128*NREQ: block per requester; slice i is `[128*i +: 128]`.
- `req_key`  in  32*Nk*NREQ: key per requester; slice i is `[32*Nk*i +: 32*Nk]`.
- `resp_valid`  out  1: response valid.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_id`  out  IDW: requester index of the response.
- `resp_data`  out  128: result block.
- `resp_err`  out  1: timeout occurred; `resp_data` is 0.
- `busy`  out  1: state ≠ IDLE.
- `enc_load`, `dec_load`  out  1: one-cycle start pulse to the respective core.
- `enc_pt`, `dec_ct`  out  128: core input block.
- `enc_key`, `dec_key`  out  32*Nk: core key.
- `enc_ct`, `dec_pt`  in  128: core result.
- `enc_valid`, `dec_valid`  in  1: core result valid.

## Operation
- States: IDLE → LOAD → WAIT → RESP → IDLE.
- **IDLE:**
  - Grant goes to the first i with `req_valid[i]` high, searching from `rr_ptr` upward modulo NREQ.
  - `req_ready[grant]` = 1 combinationally; all other bits are 0.
  - On handshake: capture data, key, mode and ID into job registers; go to LOAD.
- **LOAD:**
  - Pulse `enc_load` if mode = 0, else `dec_load`, for exactly one cycle.
  - Clear the watchdog counter; go to WAIT.
- **WAIT:**
  - Sample only the selected core's valid. The other core's valid is ignored, as is any valid seen in LOAD.
  - On valid: capture the core result into `resp_data`, set `resp_err` = 0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without valid: `resp_data` = 0, `resp_err` = 1, go to RESP.
  - If valid and timeout occur in the same cycle, valid wins.
- **RESP:**
  - Hold `resp_valid` and the response fields stable until `resp_ready`.
  - On handshake: `rr_ptr` = (grant ID + 1) mod NREQ; go to IDLE.
- Core data and key outputs are driven continuously from the job registers, so they stay stable from LOAD until the next job is captured.
- Both cores receive the same job registers; only the load pulse selects the core.
- No request is accepted outside IDLE; `req_ready` is all-zero there.
- Watchdog counter width is `$clog2(TIMEOUT)`; it never wraps within a job.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `req_ready` 0, `resp_valid` 0, `resp_err` 0, `resp_id` 0, `resp_data` 0, `enc_load` and `dec_load` 0, core data/key outputs 0, `busy` 0.
- Request handshake in cycle T:
  - LOAD in T+1, with `enc_load`/`dec_load` high in T+1 only.
  - WAIT from T+2.
- Core valid sampled in cycle V ≥ T+2 → `resp_valid` high from V+1.
- Timeout: with no valid, `resp_valid` = 1 with `resp_err` = 1 at cycle T+2+TIMEOUT.
- Response handshake in cycle R → IDLE in R+1. The earliest next `req_ready` is R+1, giving a back-to-back job spacing of at least 4 cycles.
- Reset asserted mid-job:
  - All outputs return to reset values immediately.
  - The in-flight job is dropped without a response.
  - A late core valid after reset is ignored, because state is IDLE.
- `req_valid` deasserting in IDLE before a grant is legal; the grant re-evaluates every cycle.

## Test plan
- **Encrypt, real core:** requester 0, mode 0, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff → `resp_id` 0, `resp_data` 69c4e0d86a7b0430d8cdb78070b4c55a, `resp_err` 0; exactly one `enc_load` pulse and no `dec_load`.
- **Decrypt, real core:** requester 2, mode 1, same key, data 69c4e0d86a7b0430d8cdb78070b4c55a → `resp_id` 2, `resp_data` 00112233445566778899aabbccddeeff.
- **Round-robin fairness:** all four requesters hold `req_valid` continuously, with `resp_ready` tied 1 → grant order 0,1,2,3,0,…; no requester granted twice before all others are served.
- **Response backpressure:** `resp_ready` held low for 10 cycles in RESP → response fields stable throughout; no `req_ready` asserted; `rr_ptr` is unchanged until the handshake.
- **Timeout:** core stub never asserts valid, TIMEOUT = 64 → `resp_err` = 1, `resp_data` = 0, `resp_valid` at T+66 after handshake T; the next request is then served normally.
- **Reset mid-WAIT:** `rst_n` low for 1 cycle during WAIT → all outputs at reset values; the stub's subsequent valid produces no response; `rr_ptr` = 0.

Source files
------------

// File: rtl/aes_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aes_job_arbiter
// Description : Round-robin arbiter that shares one AES encrypt core and one
//               AES decrypt core among NREQ requesters. Each granted job is
//               loaded into the selected core and watched by a watchdog. The
//               result, or an error on timeout, is returned on a single
//               response channel that is tagged with the requester ID.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_job_arbiter #(
  parameter int Nk      = 4,
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_mode,
  input  logic [128*NREQ-1:0]     req_data,
  input  logic [32*Nk*NREQ-1:0]   req_key,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [127:0]            resp_data,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    enc_load,
  output logic                    dec_load,
  output logic [127:0]            enc_pt,
  output logic [127:0]            dec_ct,
  output logic [32*Nk-1:0]        enc_key,
  output logic [32*Nk-1:0]        dec_key,
  input  logic [127:0]            enc_ct,
  input  logic [127:0]            dec_pt,
  input  logic                    enc_valid,
  input  logic                    dec_valid
);

  localparam int             KW       = 32 * Nk;
  localparam int             CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic [IDW-1:0]   rr_q,       rr_d;
  logic [127:0]     job_data_q, job_data_d;
  logic [KW-1:0]    job_key_q,  job_key_d;
  logic             job_mode_q, job_mode_d;
  logic [IDW-1:0]   job_id_q,   job_id_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [127:0]     rdata_q,    rdata_d;
  logic             rerr_q,     rerr_d;

  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_vld;
  logic             core_vld;
  logic [127:0]     core_res;

  // Round-robin search: scanning offsets from the top down lets the smallest
  // offset from rr_q overwrite the others, so no early exit is needed.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_q) + k) % NREQ);
      if (req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // Only the core that owns the current job is observed.
  always_comb begin
    core_vld = job_mode_q ? dec_valid : enc_valid;
    core_res = job_mode_q ? dec_pt    : enc_ct;
  end

  // Next-state, job capture, watchdog and handshake outputs.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    job_data_d = job_data_q;
    job_key_d  = job_key_q;
    job_mode_d = job_mode_q;
    job_id_d   = job_id_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    req_ready  = '0;
    enc_load   = 1'b0;
    dec_load   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt_id] = 1'b1;
          job_data_d        = req_data[128*gnt_id +: 128];
          job_key_d         = req_key[KW*gnt_id +: KW];
          job_mode_d        = req_mode[gnt_id];
          job_id_d          = gnt_id;
          state_d           = S_LOAD;
        end
      end
      S_LOAD: begin
        enc_load = ~job_mode_q;
        dec_load = job_mode_q;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last watchdog cycle still takes priority.
        if (core_vld) begin
          rdata_d = core_res;
          rerr_d  = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          rr_d    = (job_id_q == ID_LAST) ? '0 : job_id_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and job registers; reset drops any in-flight job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      job_data_q <= '0;
      job_key_q  <= '0;
      job_mode_q <= 1'b0;
      job_id_q   <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      job_data_q <= job_data_d;
      job_key_q  <= job_key_d;
      job_mode_q <= job_mode_d;
      job_id_q   <= job_id_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rerr_q     <= rerr_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = job_id_q;
  assign resp_data  = rdata_q;
  assign resp_err   = rerr_q;
  assign enc_pt     = job_data_q;
  assign dec_ct     = job_data_q;
  assign enc_key    = job_key_q;
  assign dec_key    = job_key_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_job_arbiter
// Description : Self-checking bench for aes_job_arbiter. It uses behavioural
//               core stubs with random latency and noise on the idle core, and
//               a transaction-level model of grant order and response content.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_job_arbiter;

  localparam int NK      = 4;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;
  localparam int KW      = 32 * NK;
  localparam int HANG    = 100000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_mode;
  logic [128*NREQ-1:0]   req_data;
  logic [KW*NREQ-1:0]    req_key;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [127:0]          resp_data;
  logic                  resp_err;
  logic                  busy;
  logic                  enc_load, dec_load;
  logic [127:0]          enc_pt, dec_ct;
  logic [KW-1:0]         enc_key, dec_key;
  logic [127:0]          enc_ct, dec_pt;
  logic                  enc_valid, dec_valid;

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = 0;

  always #5 clk = ~clk;

  aes_job_arbiter #(.Nk(NK), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_data(req_data), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .enc_load(enc_load), .dec_load(dec_load),
    .enc_pt(enc_pt), .dec_ct(dec_ct), .enc_key(enc_key), .dec_key(dec_key),
    .enc_ct(enc_ct), .dec_pt(dec_pt), .enc_valid(enc_valid), .dec_valid(dec_valid)
  );

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in core transforms, deliberately different for the two cores.
  function automatic logic [127:0] enc_model(input logic [127:0] d, input logic [KW-1:0] k);
    return d ^ k ^ 128'h5a5a_5a5a_0f0f_0f0f_3c3c_3c3c_9696_9696;
  endfunction

  function automatic logic [127:0] dec_model(input logic [127:0] d, input logic [KW-1:0] k);
    return {d[63:0], d[127:64]} ^ ~k;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // First requested index at or after the round-robin pointer.
  function automatic int pick(input logic [NREQ-1:0] mask, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (mask[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  task automatic core_noise();
    enc_valid = 1'($urandom);
    dec_valid = 1'($urandom);
    enc_ct    = rnd128();
    dec_pt    = rnd128();
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_data[128*i +: 128] = rnd128();
      req_key[KW*i +: KW]    = rnd128();
    end
    req_mode = NREQ'($urandom);
  endtask

  // One complete job: grant, load, wait (latency lat, or no result if lat
  // is beyond the watchdog), response with bp stall cycles. Optionally the
  // job is cut short by a reset pulse during WAIT.
  task automatic run_job(input logic [NREQ-1:0] mask_in, input int lat, input int bp,
                         input bit rst_mid, output int gobs);
    logic [NREQ-1:0] mask;
    logic [127:0]    d, exp_data, res;
    logic [KW-1:0]   k;
    logic            m, exp_err;
    int              g;

    gobs = -1;
    repeat ($urandom_range(0, 1)) begin
      @(negedge clk);
      req_valid  = '0;
      resp_ready = 1'($urandom);
      core_noise();
      #1;
      chk_eq("idle_no_ready", req_ready, 0);
      chk_eq("idle_busy", busy, 0);
      chk_eq("idle_resp_valid", resp_valid, 0);
    end

    // IDLE: grant
    @(negedge clk);
    rand_reqs();
    mask       = (mask_in != 0) ? mask_in : NREQ'($urandom_range(1, (1 << NREQ) - 1));
    req_valid  = mask;
    resp_ready = 1'b0;
    core_noise();
    #1;
    g = pick(mask, rr_m);
    chk_eq("grant_onehot", req_ready, 128'(1) << g);
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) gobs = i;
    d = req_data[128*g +: 128];
    k = req_key[KW*g +: KW];
    m = req_mode[g];
    res = m ? dec_model(d, k) : enc_model(d, k);

    // LOAD: the selected core shows a stale valid that must be ignored
    @(negedge clk);
    req_valid = NREQ'($urandom);
    rand_reqs();
    core_noise();
    if (m) dec_valid = 1'b1; else enc_valid = 1'b1;
    #1;
    chk_eq("load_enc", enc_load, !m);
    chk_eq("load_dec", dec_load, m);
    chk_eq("load_no_ready", req_ready, 0);
    chk_eq("load_busy", busy, 1);
    chk_eq("core_enc_pt", enc_pt, d);
    chk_eq("core_dec_ct", dec_ct, d);
    chk_eq("core_enc_key", enc_key, k);
    chk_eq("core_dec_key", dec_key, k);

    // WAIT
    exp_err  = 1'b1;
    exp_data = '0;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      if (rst_mid && c == 2) begin
        rst_n     = 1'b0;
        req_valid = '0;
        enc_valid = 1'b0;
        dec_valid = 1'b0;
        #1;
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_resp_valid", resp_valid, 0);
        chk_eq("rst_resp_err", resp_err, 0);
        chk_eq("rst_resp_id", resp_id, 0);
        chk_eq("rst_resp_data", resp_data, 0);
        chk_eq("rst_loads", {enc_load, dec_load}, 0);
        chk_eq("rst_ready", req_ready, 0);
        chk_eq("rst_core_data", {enc_pt ^ dec_ct}, 0);
        chk_eq("rst_enc_pt", enc_pt, 0);
        chk_eq("rst_enc_key", enc_key, 0);
        chk_eq("rst_dec_key", dec_key, 0);
        @(negedge clk);
        rst_n = 1'b1;
        if (m) begin dec_valid = 1'b1; dec_pt = res; end
        else   begin enc_valid = 1'b1; enc_ct = res; end
        #1;
        chk_eq("late_valid_busy", busy, 0);
        chk_eq("late_valid_resp", resp_valid, 0);
        @(negedge clk);
        enc_valid = 1'b0;
        dec_valid = 1'b0;
        #1;
        chk_eq("late_valid_resp2", resp_valid, 0);
        chk_eq("late_valid_busy2", busy, 0);
        rr_m = 0;
        return;
      end
      core_noise();
      if (m) begin dec_valid = (c == lat); dec_pt = (c == lat) ? res : rnd128(); end
      else   begin enc_valid = (c == lat); enc_ct = (c == lat) ? res : rnd128(); end
      req_valid = NREQ'($urandom);
      #1;
      chk_eq("wait_no_resp", resp_valid, 0);
      chk_eq("wait_no_load", {enc_load, dec_load}, 0);
      chk_eq("wait_no_ready", req_ready, 0);
      if (c == lat) begin
        exp_err  = 1'b0;
        exp_data = res;
        break;
      end
    end

    // RESP with backpressure
    for (int c = 0; c <= bp; c++) begin
      @(negedge clk);
      resp_ready = (c == bp);
      req_valid  = NREQ'($urandom);
      core_noise();
      #1;
      chk_eq("resp_valid", resp_valid, 1);
      chk_eq("resp_id", resp_id, g);
      chk_eq("resp_data", resp_data, exp_data);
      chk_eq("resp_err", resp_err, exp_err);
      chk_eq("resp_no_ready", req_ready, 0);
    end
    rr_m = (g + 1) % NREQ;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int gob;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_mode   = '0;
    req_data   = '0;
    req_key    = '0;
    resp_ready = 1'b0;
    enc_valid  = 1'b0;
    dec_valid  = 1'b0;
    enc_ct     = '0;
    dec_pt     = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_eq("reset_busy", busy, 0);
    chk_eq("reset_resp_valid", resp_valid, 0);
    chk_eq("reset_resp_fields", {resp_err, resp_id}, 0);
    chk_eq("reset_resp_data", resp_data, 0);
    chk_eq("reset_core_in", enc_pt, 0);
    chk_eq("reset_loads", {enc_load, dec_load}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all requesters always valid, order must be 0,1,2,3,0,...
    for (int j = 0; j < 8; j++) begin
      run_job('1, $urandom_range(0, 6), 0, 1'b0, gob);
      chk_eq("rr_order", gob, j % NREQ);
    end

    run_job('0, HANG, 0, 1'b0, gob);             // watchdog timeout
    run_job('0, 3, 0, 1'b0, gob);                // served normally after timeout
    run_job('0, 4, 10, 1'b0, gob);               // 10 cycles of backpressure
    run_job('0, TIMEOUT - 1, 2, 1'b0, gob);      // valid on the final watchdog cycle
    run_job('0, 0, 1, 1'b0, gob);                // earliest possible result
    run_job('0, 5, 0, 1'b1, gob);                // reset during WAIT
    run_job('1, 2, 0, 1'b0, gob);                // pointer back at 0 after reset
    chk_eq("rr_after_reset", gob, 0);

    for (int j = 0; j < 30; j++) begin
      int lat;
      lat = ($urandom_range(0, 7) == 0) ? HANG : $urandom_range(0, 12);
      run_job('0, lat, $urandom_range(0, 3), 1'b0, gob);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
